// File: rtl/tm1638_key_conditioner.sv
// tm1638_key_conditioner: per-key debounce, press/release pulses, key encoder.
// Optional auto-repeat of press pulses: define TM1638_KEY_AUTOREPEAT_EN.
module tm1638_key_conditioner #(
  parameter int clk_mhz          = 125,
  parameter int w_key            = 8,
  parameter int debounce_ms      = 10,
  parameter int repeat_delay_ms  = 500,
  parameter int repeat_period_ms = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [w_key-1:0]         keys_raw,
  output logic [w_key-1:0]         key_state,
  output logic [w_key-1:0]         key_press,
  output logic [w_key-1:0]         key_release,
  output logic                     key_valid,
  output logic [$clog2(w_key)-1:0] key_code
);

  localparam int tms = clk_mhz * 1000;
  localparam int pw  = (tms > 1) ? $clog2(tms) : 1;
  localparam int cw  = $clog2(debounce_ms + 1);
  localparam int kw  = $clog2(w_key);

  logic [w_key-1:0] sync1, sync2;
  logic [pw-1:0]    pre;
  logic             tick;
  logic [cw-1:0]    cnt   [w_key];
  logic [cw-1:0]    cnt_n [w_key];
  logic [w_key-1:0] st_n, prs_n, rel_n;
  logic [kw-1:0]    code_n;

`ifdef TM1638_KEY_AUTOREPEAT_EN
  localparam int rmax = (repeat_delay_ms > repeat_period_ms) ?
                        repeat_delay_ms : repeat_period_ms;
  localparam int rw   = $clog2(rmax + 1);

  logic [rw-1:0]    rpt   [w_key];
  logic [rw-1:0]    rpt_n [w_key];
  logic [w_key-1:0] first, first_n;
`endif

  assign tick = (pre == pw'(tms - 1));

  // Two-flop synchronizer for the asynchronous key bits
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys_raw;
      sync2 <= sync1;
    end
  end

  // Free-running 1 ms prescaler
  always_ff @(posedge clk) begin
    if (rst)
      pre <= '0;
    else if (tick)
      pre <= '0;
    else
      pre <= pre + 1'b1;
  end

  // Next-state: debounce counters, edge pulses and optional repeat
  always_comb begin
    st_n  = key_state;
    prs_n = '0;
    rel_n = '0;
    cnt_n = cnt;
`ifdef TM1638_KEY_AUTOREPEAT_EN
    rpt_n   = rpt;
    first_n = first;
`endif
    for (int i = 0; i < w_key; i++) begin
      if (sync2[i] == key_state[i]) begin
        cnt_n[i] = '0;
      end else if (tick) begin
        if (cnt[i] == cw'(debounce_ms - 1)) begin
          st_n[i]  = ~key_state[i];
          cnt_n[i] = '0;
          if (key_state[i])
            rel_n[i] = 1'b1;
          else
            prs_n[i] = 1'b1;
        end else begin
          cnt_n[i] = cnt[i] + 1'b1;
        end
      end
`ifdef TM1638_KEY_AUTOREPEAT_EN
      if (!st_n[i] || prs_n[i]) begin
        rpt_n[i]   = '0;
        first_n[i] = 1'b1;
      end else if (tick) begin
        if (rpt[i] == (first[i] ? rw'(repeat_delay_ms - 1)
                                : rw'(repeat_period_ms - 1))) begin
          prs_n[i]   = 1'b1;
          rpt_n[i]   = '0;
          first_n[i] = 1'b0;
        end else begin
          rpt_n[i] = rpt[i] + 1'b1;
        end
      end
`endif
    end
  end

  // Lowest-index pressed key wins
  always_comb begin
    code_n = '0;
    for (int i = w_key - 1; i >= 0; i--)
      if (key_state[i])
        code_n = kw'(i);
  end

  // Registered debounce state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      for (int i = 0; i < w_key; i++)
        cnt[i] <= '0;
    end else begin
      key_state   <= st_n;
      key_press   <= prs_n;
      key_release <= rel_n;
      key_valid   <= |key_state;
      key_code    <= code_n;
      cnt         <= cnt_n;
    end
  end

`ifdef TM1638_KEY_AUTOREPEAT_EN
  // Per-key repeat tick counters
  always_ff @(posedge clk) begin
    if (rst) begin
      first <= '1;
      for (int i = 0; i < w_key; i++)
        rpt[i] <= '0;
    end else begin
      first <= first_n;
      rpt   <= rpt_n;
    end
  end
`endif

endmodule
